ssp_txfifo: RTL
===============

Name: ssp_txfifo

Overview:
- Transmit-side FIFO of the SSP block.
- Buffers bytes written by the APB host (PSEL/PWRITE/PWDATA) and presents them in order to the serial transmit logic over a valid/ready handshake.
- Raises SSPTXINTR while full, so software stops writing.
- Counterpart of the receive FIFO, which moves serial data toward APB reads.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of PWDATA/TxData.
- DEPTH, 4, number of entries; power of 2, at least 2.
- ADDR_WIDTH, 2, log2(DEPTH); pointer width.

Ports:
- PCLK  input  1  single clock; all state updates on its rising edge.
- CLEAR  input  1  asynchronous, active-high reset.
- PSEL  input  1  APB select; host holds it high for exactly one PCLK per transfer.
- PWRITE  input  1  APB direction; 1 = write into FIFO.
- PWDATA  input  DATA_WIDTH  APB write data.
- tx_ready  input  1  transmit logic can take a word this cycle.
- TxData  output  DATA_WIDTH  head-of-FIFO word for the transmitter.
- tx_valid  output  1  TxData holds a valid unsent word.
- SSPTXINTR  output  1  FIFO full.
- tx_overrun  output  1  sticky: a write was attempted while full.
- tx_level  output  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.

Behaviour:
- Reset (CLEAR=1, asynchronous, takes effect without a clock edge):
  - rd_ptr=0, wr_ptr=0, count=0, all storage cleared to 0.
  - Outputs: SSPTXINTR=0, tx_overrun=0, tx_valid=0, TxData=0, tx_level=0.
  - Held for as long as CLEAR=1. First push is possible on the first PCLK edge after CLEAR falls.
  - Reset mid-stream discards all stored words. An in-flight tx_ready is ignored.
- Push condition: push = PSEL & PWRITE & ~full, where full = (count==DEPTH) as registered at the start of the cycle.
  - On push: mem[wr_ptr] <= PWDATA; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop condition: pop = tx_valid & tx_ready.
  - On pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Reads: PSEL & ~PWRITE has no effect on the FIFO; it is not an error.
- Count update, one of four cases:
  - push only: count+1.
  - pop only: count-1.
  - both: unchanged.
  - neither: unchanged.
- tx_level = count.
- tx_valid = (count != 0). TxData = mem[rd_ptr] when tx_valid, else 0. Both derive from registered state only, with no combinational path from PWDATA or tx_ready.
- Latency: a word pushed at edge N appears on TxData/tx_valid after edge N when the FIFO was empty, i.e. 1 cycle.
- Ordering: strict FIFO, no reordering, no word duplicated or skipped. Equal consecutive values are stored as separate entries.
- SSPTXINTR = (count==DEPTH), registered. It rises on the edge completing the DEPTH-th push and falls on the edge of the pop that leaves DEPTH-1.
- Full boundary:
  - A write attempt while full is dropped: storage, wr_ptr and count are unchanged, and tx_overrun <= 1.
  - This holds even if a pop occurs in the same cycle: that pop completes, count becomes DEPTH-1, and the write is still lost.
- tx_overrun clears only on CLEAR.
- Empty boundary:
  - tx_valid=0, so tx_ready is ignored and no pop occurs.
  - A push into an empty FIFO in the same cycle as tx_ready=1 is not popped that cycle.
- Simultaneous push and pop at 0 < count < DEPTH: both take effect, count is unchanged, and the pointers advance independently.
- Wrap-around: after DEPTH pushes and DEPTH pops the pointers return to 0. Ordering must hold across any number of wraps.
- Transmit-side contract: the transmitter samples TxData on the edge where tx_valid & tx_ready. TxData is stable while tx_valid=1 and tx_ready=0.

Test Plan:
1. Reset and first word:
   - Stimulus: CLEAR pulse, then push 0xA5 with tx_ready=0.
   - Required: after one edge, tx_valid=1, TxData=0xA5, tx_level=1, SSPTXINTR=0.
2. Fill and overrun:
   - Stimulus: push 0x11,0x22,0x33,0x44, then push 0x55.
   - Required: SSPTXINTR=1 and tx_level=4 after the 4th push. 0x55 is dropped, tx_overrun=1, tx_level stays 4.
   - Then drain with tx_ready=1. Required: TxData sequence 0x11,0x22,0x33,0x44; SSPTXINTR falls after the first pop.
3. Simultaneous push/pop:
   - Stimulus: with 2 entries (0x01,0x02) stored, push 0x03 while tx_ready=1.
   - Required: 0x01 consumed, tx_level stays 2, subsequent order 0x02,0x03.
4. Wrap-around:
   - Stimulus: 10 words 0x00..0x09, interleaving pushes and pops with random tx_ready.
   - Required: output order exactly 0x00..0x09, no loss, tx_overrun=0.
5. Empty and read robustness:
   - Stimulus: tx_ready=1 with empty FIFO; PSEL=1, PWRITE=0 for 3 cycles.
   - Required: tx_valid=0, tx_level=0, pointers unchanged.
6. Async reset mid-operation:
   - Stimulus: 3 entries stored plus tx_overrun=1, assert CLEAR between clock edges.
   - Required: outputs go to reset values immediately without a PCLK edge. The next push of 0x7E appears as the head with tx_level=1.

Source files
------------

// File: rtl/ssp_txfifo.sv
// SSP transmit FIFO: buffers APB-written words and hands them to the serial
// transmitter over a valid/ready handshake; flags full and sticky overrun.
module ssp_txfifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  PSEL,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] TxData,
  output logic                  tx_valid,
  output logic                  SSPTXINTR,
  output logic                  tx_overrun,
  output logic [ADDR_WIDTH:0]   tx_level
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  overrun;

  logic full;
  logic write_req;
  logic push;
  logic pop;

  // Full is judged on the registered count, so a pop in the same cycle
  // does not rescue a write attempted while full.
  assign full      = (count == FULL_CNT);
  assign write_req = PSEL & PWRITE;
  assign push      = write_req & ~full;
  assign pop       = tx_valid & tx_ready;

  assign tx_valid   = (count != '0);
  assign TxData     = tx_valid ? mem[rd_ptr] : '0;
  assign SSPTXINTR  = full;
  assign tx_overrun = overrun;
  assign tx_level   = count;

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      // NOTE: storage is cleared on reset here because the block's reset
      // contract requires it; a plain FIFO RAM would normally be left
      // unreset so it can map onto memory macros.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // the values at the start of the cycle, independent of statement order.
      if (push) begin
        mem[wr_ptr] <= PWDATA;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (write_req && full) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
